// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// Imported by the LSU top and its load alignment helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shift the addressed lane down and
// sign- or zero-extend according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [31:0] sh;

  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    ext = 32'd0;
    unique case (funct3)
      LB:      ext = {{24{sh[7]}}, sh[7:0]};
      LH:      ext = {{16{sh[15]}}, sh[15:0]};
      LW:      ext = sh;
      LBU:     ext = {24'd0, sh[7:0]};
      LHU:     ext = {16'd0, sh[15:0]};
      default: ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with a req/gnt/rvalid data bus.
// Stalls the core from acceptance until the done cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t state;

  logic [1:0]  off;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        illegal;
  logic        misal;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] ext;

  assign off = addr[1:0];

  always_comb begin
    illegal = 1'b0;
    if (is_store)
      illegal = !(funct3 == SB || funct3 == SH || funct3 == SW);
    else
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110)
             || (funct3 == 3'b111);
  end

  // funct3[1:0] encodes access size for every legal op
  always_comb begin
    misal = 1'b0;
    unique case (funct3[1:0])
      2'b01:   misal = off[0];
      2'b10:   misal = |off;
      default: misal = 1'b0;
    endcase
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be_n = 4'b0001 << off;
        wd_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n = 4'b0011 << off;
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

  lsu_load_align u_align (
    .mem_rdata (mem_rdata),
    .off       (off_q),
    .funct3    (f3_q),
    .ext       (ext)
  );

  assign stall = (state == IDLE && ls_valid)
              || state == REQ || state == WAIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      lsu_err   <= 1'b0;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
    end else begin
      done    <= 1'b0;
      lsu_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ls_valid) begin
            if (illegal || misal) begin
              state   <= DONE;
              done    <= 1'b1;
              lsu_err <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wd_n;
              off_q     <= off;
              f3_q      <= funct3;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata <= ext;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table,
// hand-written reset sequences and randomized accesses.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid),
    .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .stall(stall), .rdata(rdata),
    .done(done), .lsu_err(lsu_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_bad(input bit st, input logic [2:0] f3,
                               input logic [31:0] a);
    int size;
    bit legal;
    if (st) legal = (f3 <= 3'd2);
    else legal = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5;
    if (!legal) return 1'b1;
    size = 1 << f3[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] s;
    int v;
    s = d >> (8 * a[1:0]);
    case (f3)
      3'd0: begin v = int'(s[7:0]); if (v > 127) v -= 256; end
      3'd1: begin v = int'(s[15:0]); if (v > 32767) v -= 65536; end
      3'd4: v = int'(s[7:0]);
      3'd5: v = int'(s[15:0]);
      default: v = int'(s);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int size = 1 << f3[1:0];
    int lanes = (1 << size) - 1;
    return 4'(lanes << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] d);
    if (f3[1:0] == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
    if (f3[1:0] == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  // One access from acceptance to done, bus answered after gd/rvd waits
  task automatic access(input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mrd, input int gd,
                        input int rvd, output logic [31:0] adr_seen,
                        output logic [3:0] be_seen,
                        output logic [31:0] wd_seen);
    bit bad;
    int edone;
    bit in_req;
    bad = m_bad(st, f3, a);
    edone = bad ? 1 : (st ? 2 + gd : 3 + gd + rvd);
    if (!bad && !st) model_rdata = m_load(f3, a, mrd);
    adr_seen = 32'hx;
    be_seen = 4'hx;
    wd_seen = 32'hx;
    @(posedge clk); #1;
    ls_valid = 1'b1; is_store = st; funct3 = f3;
    addr = a; wdata = wd; mem_rdata = mrd;
    for (int c = 0; c <= edone; c++) begin
      in_req = !bad && c >= 1 && c <= 1 + gd;
      mem_gnt = !bad && c == 1 + gd;
      mem_rvalid = !bad && !st && c == 2 + gd + rvd;
      if (c >= 1) begin
        addr = $urandom;
        wdata = $urandom;
      end
      @(negedge clk);
      chk("stall", 32'(stall), 32'(c < edone));
      chk("done", 32'(done), 32'(c == edone));
      chk("mem_req", 32'(mem_req), 32'(in_req));
      if (in_req) begin
        chk("mem_addr", mem_addr, a & ~32'h3);
        chk("mem_we", 32'(mem_we), 32'(st));
        if (st) begin
          chk("mem_be", 32'(mem_be), 32'(m_be(f3, a)));
          chk("mem_wdata", mem_wdata, m_wd(f3, wd));
        end
        adr_seen = mem_addr;
        be_seen = mem_be;
        wd_seen = mem_wdata;
      end
      if (c == edone) begin
        chk("lsu_err", 32'(lsu_err), 32'(bad));
        chk("rdata", rdata, model_rdata);
      end
      @(posedge clk); #1;
    end
    ls_valid = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mrd;
    int          gd;
    int          rvd;
    logic [31:0] exp_adr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [31:0] as;
    logic [3:0]  bs;
    logic [31:0] ws;
    rst = 1'b1; ls_valid = 1'b1; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #12;
    chk("rst_stall_hi", 32'(stall), 32'd1);
    ls_valid = 1'b0; #1;
    chk("rst_stall_lo", 32'(stall), 32'd0);
    chk("rst_outs", {mem_req, mem_we, done, lsu_err, mem_be},
        32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    vt[0]  = '{1, SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
               32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1, SB, 32'h103, 32'h000000A5, 32'h0, 0, 0,
               32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vt[2]  = '{0, LB, 32'h202, 32'h0, 32'h00800000, 0, 0,
               32'h200, 4'h0, 32'h0, 32'hFFFFFF80};
    vt[3]  = '{0, LBU, 32'h202, 32'h0, 32'h00800000, 0, 0,
               32'h200, 4'h0, 32'h0, 32'h00000080};
    vt[4]  = '{0, LH, 32'h202, 32'h0, 32'h80011234, 1, 1,
               32'h200, 4'h0, 32'h0, 32'hFFFF8001};
    vt[5]  = '{0, LW, 32'h300, 32'h0, 32'h12345678, 2, 3,
               32'h300, 4'h0, 32'h0, 32'h12345678};
    vt[6]  = '{0, LW, 32'h101, 32'h0, 32'hFFFFFFFF, 0, 0,
               32'h0, 4'h0, 32'h0, 32'h12345678};
    vt[7]  = '{0, 3'b011, 32'h104, 32'h0, 32'hFFFFFFFF, 0, 0,
               32'h0, 4'h0, 32'h0, 32'h12345678};
    vt[8]  = '{1, SH, 32'h102, 32'h1234BEEF, 32'h0, 1, 0,
               32'h100, 4'b1100, 32'hBEEFBEEF, 32'h12345678};
    vt[9]  = '{1, 3'b100, 32'h108, 32'h55, 32'h0, 0, 0,
               32'h0, 4'h0, 32'h0, 32'h12345678};
    vt[10] = '{0, LHU, 32'h106, 32'h0, 32'hABCD0000, 0, 2,
               32'h104, 4'h0, 32'h0, 32'h0000ABCD};

    foreach (vt[i]) begin
      access(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, vt[i].mrd,
             vt[i].gd, vt[i].rvd, as, bs, ws);
      chk($sformatf("tbl%0d_rdata", i), rdata, vt[i].exp_rd);
      if (vt[i].exp_adr != 32'h0)
        chk($sformatf("tbl%0d_addr", i), as, vt[i].exp_adr);
      if (vt[i].exp_be != 4'h0) begin
        chk($sformatf("tbl%0d_be", i), 32'(bs), 32'(vt[i].exp_be));
        chk($sformatf("tbl%0d_wd", i), ws, vt[i].exp_wd);
      end
    end

    // reset while the request is pending
    @(posedge clk); #1;
    ls_valid = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h400;
    @(posedge clk); #1;
    chk("rq_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1; #1;
    chk("rq_req_drop", 32'(mem_req), 32'd0);
    chk("rq_stall_idle", 32'(stall), 32'd1);
    ls_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rq_done", 32'(done), 32'd0);
    chk("rq_rdata", rdata, 32'd0);
    model_rdata = 32'd0;

    // reset in WAIT followed by a stray rvalid
    @(posedge clk); #1;
    ls_valid = 1'b1; funct3 = LW; addr = 32'h404;
    @(posedge clk); #1; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    chk("wt_stall", 32'(stall), 32'd1);
    chk("wt_req", 32'(mem_req), 32'd0);
    rst = 1'b1; ls_valid = 1'b0; #1;
    chk("wt_stall_rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wt_stray_done", 32'(done), 32'd0);
      chk("wt_stray_rdata", rdata, 32'd0);
      chk("wt_stray_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    access(0, LW, 32'h408, 32'h0, 32'hCAFEF00D, 0, 1, as, bs, ws);
    chk("post_rst_lw", rdata, 32'hCAFEF00D);

    // randomized accesses against the reference model
    for (int n = 0; n < 250; n++) begin
      bit st;
      st = $urandom_range(0, 1) == 1;
      access(st, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             as, bs, ws);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
